mcu_interest_queue: RTL and testbench

Sits between `spi_mcu` and the router core on the user side of the NDN router. It buffers interest packets received from the MCU and forwards them to the router with a valid/ready handshake. Each forwarded interest is recorded in a small pending-interest table (PIT). Data packets returned by the router are matched against the PIT; only data that satisfies an outstanding interest is pulsed back to `spi_mcu` for transmission to the MCU.

---
 rtl/mcu_interest_queue.sv | 164 ++++++++++++++++
 tb/tb_mcu_interest_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_interest_queue.sv
// Interest queue between spi_mcu and the router core: buffers MCU interests,
// tracks them in a small PIT and returns only data that satisfies one of them.
module mcu_interest_queue #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PIT_ENTRIES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_meta_data,
   input  logic [63:0]  rx_prefix,
   output logic         interest_valid,
   input  logic         interest_ready,
   output logic [7:0]   interest_meta_data,
   output logic [63:0]  interest_prefix,
   input  logic         data_valid,
   output logic         data_ready,
   input  logic [63:0]  data_prefix,
   input  logic [255:0] data_payload,
   output logic         tx_valid,
   output logic [7:0]   tx_meta_data,
   output logic [63:0]  tx_prefix,
   output logic [255:0] tx_data,
   output logic [7:0]   drop_count,
   output logic [7:0]   unmatched_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = (PIT_ENTRIES > 1) ? $clog2(PIT_ENTRIES) : 1;

   // Top L bits set; L == 0 encodes a full 64-bit compare
   function automatic logic [63:0] len_mask(input logic [5:0] l);
      if (l == 6'd0) return '1;
      return ~((64'h1 << (7'd64 - 7'(l))) - 64'h1);
   endfunction

   logic [71:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         fifo_empty, fifo_full;
   logic [71:0]  head;
   logic         push, pop, drop;

   logic [PIT_ENTRIES-1:0] pit_valid;
   logic [5:0]             pit_len    [PIT_ENTRIES];
   logic [63:0]            pit_prefix [PIT_ENTRIES];
   logic                   pit_has_free;
   logic [PW-1:0]          alloc_idx;

   logic                   m_valid;
   logic [63:0]            m_prefix;
   logic [255:0]           m_payload;
   logic [PIT_ENTRIES-1:0] hit_vec;
   logic                   any_hit;
   logic [PW-1:0]          hit_idx;

   logic [63:0]            tx_prefix_q;
   logic [255:0]           tx_data_q;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head       = fifo_mem[rd_ptr[AW-1:0]];

   assign interest_valid     = !fifo_empty && pit_has_free;
   assign interest_meta_data = interest_valid ? head[71:64] : 8'h00;
   assign interest_prefix    = interest_valid ? head[63:0]  : 64'h0;

   assign pop  = interest_valid && interest_ready;
   assign push = rx_valid && rx_meta_data[6] && (!fifo_full || pop);
   assign drop = rx_valid && !push;

   // Lowest-index free PIT slot
   always_comb begin
      alloc_idx    = '0;
      pit_has_free = 1'b0;
      for (int i = PIT_ENTRIES - 1; i >= 0; i--) begin
         if (!pit_valid[i]) begin
            alloc_idx    = PW'(i);
            pit_has_free = 1'b1;
         end
      end
   end

   // Prefix match of the captured data against every slot, lowest index wins
   always_comb begin
      hit_vec = '0;
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = PIT_ENTRIES - 1; i >= 0; i--) begin
         hit_vec[i] = pit_valid[i] &&
                      (((m_prefix ^ pit_prefix[i]) & len_mask(pit_len[i])) == 64'h0);
         if (hit_vec[i]) begin
            any_hit = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   assign tx_valid     = m_valid && any_hit;
   assign data_ready   = !tx_valid;
   assign tx_meta_data = 8'h00;
   assign tx_prefix    = tx_valid ? m_prefix  : tx_prefix_q;
   assign tx_data      = tx_valid ? m_payload : tx_data_q;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {rx_meta_data, rx_prefix};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Clear and allocate never target the same slot: one is valid, the other free
   always_ff @(posedge clk) begin
      if (rst) begin
         pit_valid <= '0;
      end else begin
         if (tx_valid) pit_valid[hit_idx] <= 1'b0;
         if (pop) begin
            pit_valid[alloc_idx]  <= 1'b1;
            pit_len[alloc_idx]    <= head[69:64];
            pit_prefix[alloc_idx] <= head[63:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid     <= 1'b0;
         m_prefix    <= '0;
         m_payload   <= '0;
         tx_prefix_q <= '0;
         tx_data_q   <= '0;
      end else begin
         m_valid <= data_valid && data_ready;
         if (data_valid && data_ready) begin
            m_prefix  <= data_prefix;
            m_payload <= data_payload;
         end
         if (tx_valid) begin
            tx_prefix_q <= m_prefix;
            tx_data_q   <= m_payload;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count      <= '0;
         unmatched_count <= '0;
      end else begin
         if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         if (m_valid && !any_hit && unmatched_count != 8'hFF)
            unmatched_count <= unmatched_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_mcu_interest_queue.sv
// Bench for mcu_interest_queue: directed scenarios plus random traffic checked
// against a queue/array model of the interest FIFO and PIT.
module tb_mcu_interest_queue;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx_valid;
   logic [7:0]   rx_meta_data;
   logic [63:0]  rx_prefix;
   logic         interest_valid;
   logic         interest_ready;
   logic [7:0]   interest_meta_data;
   logic [63:0]  interest_prefix;
   logic         data_valid;
   logic         data_ready;
   logic [63:0]  data_prefix;
   logic [255:0] data_payload;
   logic         tx_valid;
   logic [7:0]   tx_meta_data;
   logic [63:0]  tx_prefix;
   logic [255:0] tx_data;
   logic [7:0]   drop_count;
   logic [7:0]   unmatched_count;

   int errors = 0;
   int checks = 0;

   mcu_interest_queue dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_meta_data(rx_meta_data), .rx_prefix(rx_prefix),
      .interest_valid(interest_valid), .interest_ready(interest_ready),
      .interest_meta_data(interest_meta_data), .interest_prefix(interest_prefix),
      .data_valid(data_valid), .data_ready(data_ready),
      .data_prefix(data_prefix), .data_payload(data_payload),
      .tx_valid(tx_valid), .tx_meta_data(tx_meta_data),
      .tx_prefix(tx_prefix), .tx_data(tx_data),
      .drop_count(drop_count), .unmatched_count(unmatched_count)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, PIT as plain arrays
   logic [71:0]  mq[$];
   bit           mv [4];
   logic [5:0]   ml [4];
   logic [63:0]  mp [4];
   int           m_drop, m_unm;
   bit           mm_valid;
   logic [63:0]  mm_prefix, m_txp;
   logic [255:0] mm_payload, m_txd;

   function automatic bit pfx_eq(input logic [5:0] l, input logic [63:0] a, input logic [63:0] b);
      int n;
      n = (l == 6'd0) ? 64 : int'(l);
      if (n == 64) return a == b;
      return (a >> (64 - n)) == (b >> (64 - n));
   endfunction

   function automatic int m_hit_idx();
      for (int i = 0; i < 4; i++)
         if (mv[i] && pfx_eq(ml[i], mp[i], mm_prefix)) return i;
      return -1;
   endfunction

   function automatic bit m_ivalid();
      bit fr;
      fr = 0;
      for (int i = 0; i < 4; i++) if (!mv[i]) fr = 1;
      return (mq.size() != 0) && fr;
   endfunction

   function automatic bit m_tx();
      return mm_valid && (m_hit_idx() >= 0);
   endfunction

   // Advance one clock; the model steps with the DUT using the inputs of this cycle
   task automatic tick();
      bit pop, push, tx, cap;
      int h, a;
      logic [7:0]   meta;
      logic [63:0]  pfx, dpfx;
      logic [255:0] dpay;
      bit r, rv;
      h = m_hit_idx();
      tx = mm_valid && (h >= 0);
      pop = m_ivalid() && interest_ready;
      push = rx_valid && rx_meta_data[6] && (mq.size() < 4 || pop);
      cap = data_valid && !tx;
      a = -1;
      for (int i = 0; i < 4; i++) if (!mv[i] && a < 0) a = i;
      meta = rx_meta_data; pfx = rx_prefix; dpfx = data_prefix; dpay = data_payload;
      r = rst; rv = rx_valid;
      @(posedge clk);
      if (r) begin
         mq.delete();
         for (int i = 0; i < 4; i++) mv[i] = 0;
         m_drop = 0; m_unm = 0; mm_valid = 0;
         mm_prefix = '0; mm_payload = '0; m_txp = '0; m_txd = '0;
      end else begin
         if (rv && !push && m_drop < 255) m_drop++;
         if (mm_valid && !tx && m_unm < 255) m_unm++;
         if (tx) begin
            mv[h] = 0; m_txp = mm_prefix; m_txd = mm_payload;
         end
         if (pop) begin
            mv[a] = 1; ml[a] = mq[0][69:64]; mp[a] = mq[0][63:0];
            void'(mq.pop_front());
         end
         if (push) mq.push_back({meta, pfx});
         mm_valid = cap;
         if (cap) begin mm_prefix = dpfx; mm_payload = dpay; end
      end
      #1;
   endtask

   task automatic idle_inputs();
      rx_valid = 0; rx_meta_data = '0; rx_prefix = '0;
      interest_ready = 0; data_valid = 0; data_prefix = '0; data_payload = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic send_rx(input logic [7:0] meta, input logic [63:0] pfx);
      rx_valid = 1; rx_meta_data = meta; rx_prefix = pfx;
      tick();
      rx_valid = 0;
   endtask

   task automatic rand_inputs();
      logic [15:0] tags [4];
      logic [5:0]  lens [5];
      tags[0] = 16'hA5A5; tags[1] = 16'h1234; tags[2] = 16'hBEEF; tags[3] = 16'h0F0F;
      lens[0] = 6'd0; lens[1] = 6'd8; lens[2] = 6'd16; lens[3] = 6'd32; lens[4] = 6'd48;
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_meta_data = {1'b0, ($urandom_range(0, 7) != 0), lens[$urandom_range(0, 4)]};
      rx_prefix = {tags[$urandom_range(0, 3)], 44'h0, 4'($urandom_range(0, 1))};
      interest_ready = $urandom_range(0, 1);
      data_valid = ($urandom_range(0, 2) == 0);
      data_prefix = {tags[$urandom_range(0, 3)], 44'h0, 4'($urandom_range(0, 1))};
      if ($urandom_range(0, 3) == 0) data_prefix[40:32] = 9'($urandom);
      data_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic test_reset();
      rst = 0;
      for (int c = 0; c < 30; c++) begin rand_inputs(); tick(); end
      idle_inputs();
      rst = 1; tick(); tick(); rst = 0;
      checks++; if (interest_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %0b need 0", interest_valid); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid: got %0b need 0", tx_valid); end
      checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_dready: got %0b need 1", data_ready); end
      checks++; if (drop_count !== 8'd0 || unmatched_count !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d need 0/0", drop_count, unmatched_count); end
      checks++; if (tx_prefix !== 64'h0 || tx_data !== 256'h0 || interest_prefix !== 64'h0) begin errors++; $display("FAIL reset_data: tx_prefix %h tx_data %h ipfx %h need zeros", tx_prefix, tx_data, interest_prefix); end
   endtask

   task automatic test_round_trip();
      do_reset();
      interest_ready = 1;
      send_rx(8'h50, 64'hABCD_0000_0000_0000);
      checks++; if (interest_valid !== 1'b1 || interest_prefix !== 64'hABCD_0000_0000_0000 || interest_meta_data !== 8'h50) begin errors++; $display("FAIL rt_interest: valid %0b pfx %h meta %h need 1 abcd000000000000 50", interest_valid, interest_prefix, interest_meta_data); end
      tick();
      checks++; if (interest_valid !== 1'b0) begin errors++; $display("FAIL rt_popped: got %0b need 0", interest_valid); end
      data_valid = 1; data_prefix = 64'hABCD_1234_5678_9ABC; data_payload = 256'h1;
      tick();
      data_valid = 0;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 256'h1 || tx_prefix !== 64'hABCD_1234_5678_9ABC || tx_meta_data !== 8'h00) begin errors++; $display("FAIL rt_tx: valid %0b data %h pfx %h need 1 1 abcd123456789abc", tx_valid, tx_data, tx_prefix); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rt_dready_low: got %0b need 0", data_ready); end
      tick();
      checks++; if (tx_valid !== 1'b0 || tx_data !== 256'h1) begin errors++; $display("FAIL rt_tx_hold: valid %0b data %h need 0 1", tx_valid, tx_data); end
      checks++; if (dut.pit_valid !== 4'b0000) begin errors++; $display("FAIL rt_pit_empty: got %b need 0000", dut.pit_valid); end
   endtask

   task automatic test_fifo_and_pit_full();
      logic [63:0] p [6];
      for (int k = 0; k < 6; k++) p[k] = {16'h1000 + 16'(k), 48'h0000_0000_00F0};
      do_reset();
      interest_ready = 0;
      for (int k = 0; k < 5; k++) send_rx(8'h40, p[k]);
      tick();
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ff_drop_full: got %0d need 1", drop_count); end
      checks++; if (interest_valid !== 1'b1 || interest_prefix !== p[0]) begin errors++; $display("FAIL ff_head_hold: valid %0b pfx %h need 1 %h", interest_valid, interest_prefix, p[0]); end
      send_rx(8'h00, 64'hDEAD_0000_0000_0000);
      checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ff_drop_type: got %0d need 2", drop_count); end
      interest_ready = 1;
      for (int k = 0; k < 4; k++) tick();
      checks++; if (interest_valid !== 1'b0 || dut.pit_valid !== 4'b1111) begin errors++; $display("FAIL pit_filled: valid %0b pit %b need 0 1111", interest_valid, dut.pit_valid); end
      send_rx(8'h40, p[5]);
      tick();
      checks++; if (interest_valid !== 1'b0) begin errors++; $display("FAIL pit_full_block: got %0b need 0", interest_valid); end
      data_valid = 1; data_prefix = p[2]; data_payload = 256'hC2;
      tick();
      data_valid = 0;
      checks++; if (tx_valid !== 1'b1 || interest_valid !== 1'b0) begin errors++; $display("FAIL pit_match: tx %0b ivalid %0b need 1 0", tx_valid, interest_valid); end
      tick();
      checks++; if (interest_valid !== 1'b1 || interest_prefix !== p[5]) begin errors++; $display("FAIL pit_reopen: valid %0b pfx %h need 1 %h", interest_valid, interest_prefix, p[5]); end
      tick();
      checks++; if (dut.pit_valid !== 4'b1111 || dut.pit_prefix[2] !== p[5]) begin errors++; $display("FAIL pit_slot2: pit %b slot2 %h need 1111 %h", dut.pit_valid, dut.pit_prefix[2], p[5]); end
   endtask

   task automatic test_miss();
      do_reset();
      data_valid = 1; data_prefix = 64'h1111_1111_1111_1111; data_payload = 256'h77;
      tick();
      data_valid = 0;
      checks++; if (tx_valid !== 1'b0 || data_ready !== 1'b1) begin errors++; $display("FAIL miss_no_tx: tx %0b dready %0b need 0 1", tx_valid, data_ready); end
      checks++; if (unmatched_count !== 8'd0) begin errors++; $display("FAIL miss_count_early: got %0d need 0", unmatched_count); end
      tick();
      checks++; if (unmatched_count !== 8'd1 || tx_valid !== 1'b0) begin errors++; $display("FAIL miss_count: got %0d tx %0b need 1 0", unmatched_count, tx_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] p;
      p = 64'h0123_4567_89AB_CDEF;
      do_reset();
      interest_ready = 1;
      send_rx(8'h40, p);
      send_rx(8'h40, p);
      tick(); tick();
      checks++; if (dut.pit_valid !== 4'b0011) begin errors++; $display("FAIL b2b_alloc: got %b need 0011", dut.pit_valid); end
      data_valid = 1; data_prefix = p; data_payload = 256'hA1;
      tick();
      checks++; if (tx_valid !== 1'b1 || data_ready !== 1'b0 || tx_data !== 256'hA1) begin errors++; $display("FAIL b2b_tx1: tx %0b dready %0b data %h need 1 0 a1", tx_valid, data_ready, tx_data); end
      data_payload = 256'hB2;
      tick();
      checks++; if (tx_valid !== 1'b0 || data_ready !== 1'b1 || dut.pit_valid !== 4'b0010) begin errors++; $display("FAIL b2b_gap: tx %0b dready %0b pit %b need 0 1 0010", tx_valid, data_ready, dut.pit_valid); end
      tick();
      data_valid = 0;
      checks++; if (tx_valid !== 1'b1 || data_ready !== 1'b0 || tx_data !== 256'hB2) begin errors++; $display("FAIL b2b_tx2: tx %0b dready %0b data %h need 1 0 b2", tx_valid, data_ready, tx_data); end
      tick();
      checks++; if (dut.pit_valid !== 4'b0000 || unmatched_count !== 8'd0) begin errors++; $display("FAIL b2b_done: pit %b unm %0d need 0000 0", dut.pit_valid, unmatched_count); end
   endtask

   task automatic test_random();
      bit ev;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rand_inputs();
         tick();
         ev = m_ivalid();
         checks++; if (interest_valid !== ev) begin errors++; $display("FAIL rnd_ivalid c%0d: got %0b need %0b", c, interest_valid, ev); end
         if (ev) begin
            checks++; if ({interest_meta_data, interest_prefix} !== mq[0]) begin errors++; $display("FAIL rnd_head c%0d: got %h need %h", c, {interest_meta_data, interest_prefix}, mq[0]); end
         end
         checks++; if (tx_valid !== m_tx() || data_ready !== !m_tx()) begin errors++; $display("FAIL rnd_tx c%0d: tx %0b dready %0b need tx %0b", c, tx_valid, data_ready, m_tx()); end
         checks++; if (tx_prefix !== (m_tx() ? mm_prefix : m_txp) || tx_data !== (m_tx() ? mm_payload : m_txd)) begin errors++; $display("FAIL rnd_txdata c%0d: pfx %h data %h", c, tx_prefix, tx_data); end
         checks++; if (drop_count !== 8'(m_drop) || unmatched_count !== 8'(m_unm)) begin errors++; $display("FAIL rnd_counts c%0d: got %0d/%0d need %0d/%0d", c, drop_count, unmatched_count, m_drop, m_unm); end
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick();
      test_reset();
      test_round_trip();
      test_fifo_and_pit_full();
      test_miss();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
